oto_pilot_ctrl: RTL and testbench

- Receiving end of the autopilot sensor interface: consumes GNSS altitude, altimeter altitude, target altitude and the altitude-info valid level driven on the user GPIOs.
- Produces a debounced one-hot flight command (climb / hold / descend) on the 3 command GPIOs.
- Fuses the two sensors, compares the result to the target with hysteresis, and detects sensor disagreement.
- Sits in the user project area between the GPIO input pins (mprj_io[31:13]) and the command output pins (mprj_io[10:8]).

---
 rtl/oto_pilot_ctrl_if.sv | 22 ++
 rtl/oto_pilot_ctrl.sv | 159 +++++++++++++++
 tb/tb_oto_pilot_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/oto_pilot_ctrl_if.sv
// Sensor-to-autopilot GPIO bundle: altitude buses and valid level in, flight command out.
interface oto_pilot_ctrl_if #(
    parameter int unsigned W = 6
) ();
    logic [W-1:0] gnss_i;
    logic [W-1:0] altimetre_i;
    logic [W-1:0] hedef_yukseklik_i;
    logic         yukseklik_bilgisi_i;
    logic [2:0]   komut_o;
    logic         komut_valid_o;
    logic         sensor_fault_o;

    modport master (
        output gnss_i, altimetre_i, hedef_yukseklik_i, yukseklik_bilgisi_i,
        input  komut_o, komut_valid_o, sensor_fault_o
    );

    modport slave (
        input  gnss_i, altimetre_i, hedef_yukseklik_i, yukseklik_bilgisi_i,
        output komut_o, komut_valid_o, sensor_fault_o
    );
endinterface

// File: rtl/oto_pilot_ctrl.sv
// Autopilot command controller: fuses GNSS and barometric altitude, classifies the error
// against the target with hysteresis, and debounces the resulting climb/hold/descend command.
module oto_pilot_ctrl #(
    parameter int unsigned W        = 6,
    parameter int unsigned HYST     = 2,
    parameter int unsigned CONFIRM  = 3,
    parameter int unsigned FAULT_TH = 8
) (
    input logic              clock,
    input logic              resetb,
    oto_pilot_ctrl_if.slave  bus
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StClimb = 2'd1;
    localparam logic [1:0] StHold  = 2'd2;
    localparam logic [1:0] StDesc  = 2'd3;

    localparam logic signed [W+1:0] HystPos = (W+2)'(HYST);
    localparam logic signed [W+1:0] HystNeg = -HystPos;
    localparam logic [W-1:0]        FaultTh = W'(FAULT_TH);
    localparam logic [3:0]          ConfirmN = 4'(CONFIRM);

    // Stage 1: input capture
    logic [W-1:0] s1_gnss_q, s1_gnss_d;
    logic [W-1:0] s1_alt_q, s1_alt_d;
    logic [W-1:0] s1_tgt_q, s1_tgt_d;
    logic         s1_vld_q, s1_vld_d;

    // Stage 2: fused error and sensor disagreement
    logic signed [W+1:0] err_q, err_d;
    logic [W-1:0]        diff_q, diff_d;
    logic                s2_vld_q, s2_vld_d;
    logic [W:0]          sum;
    logic [W-1:0]        fused;

    // Stage 3: debounced decision
    logic [1:0] state_q, state_d;
    logic [1:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic       fault_q, fault_d;
    logic       valid_q, valid_d;
    logic [2:0] komut_q, komut_d;
    logic [1:0] cls;
    logic       fault_now;
    logic [3:0] cnt_inc;

    always_comb begin
        s1_gnss_d = s1_gnss_q;
        s1_alt_d  = s1_alt_q;
        s1_tgt_d  = s1_tgt_q;
        s1_vld_d  = bus.yukseklik_bilgisi_i;
        if (bus.yukseklik_bilgisi_i) begin
            s1_gnss_d = bus.gnss_i;
            s1_alt_d  = bus.altimetre_i;
            s1_tgt_d  = bus.hedef_yukseklik_i;
        end
    end

    always_comb begin
        sum      = {1'b0, s1_gnss_q} + {1'b0, s1_alt_q};
        fused    = W'(sum >> 1);
        err_d    = $signed({2'b00, s1_tgt_q} - {2'b00, fused});
        diff_d   = (s1_gnss_q >= s1_alt_q) ? (s1_gnss_q - s1_alt_q) : (s1_alt_q - s1_gnss_q);
        s2_vld_d = s1_vld_q;
    end

    always_comb begin
        if (err_q > HystPos) begin
            cls = StClimb;
        end else if (err_q < HystNeg) begin
            cls = StDesc;
        end else begin
            cls = StHold;
        end
        fault_now = (diff_q > FaultTh);
        // A new candidate restarts the run; StIdle in cand_q means "no candidate".
        cnt_inc = (cand_q == cls) ? (cnt_q + 4'd1) : 4'd1;

        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        valid_d = valid_q;

        if (!s2_vld_q) begin
            cnt_d  = 4'd0;
            cand_d = StIdle;
        end else if (fault_now) begin
            state_d = StHold;
            cnt_d   = 4'd0;
            cand_d  = StIdle;
            fault_d = 1'b1;
            valid_d = 1'b1;
        end else begin
            fault_d = 1'b0;
            if (state_q == StIdle) begin
                state_d = cls;
                valid_d = 1'b1;
                cnt_d   = 4'd0;
                cand_d  = StIdle;
            end else if (cls == state_q) begin
                cnt_d  = 4'd0;
                cand_d = StIdle;
            end else if (cnt_inc >= ConfirmN) begin
                state_d = cls;
                cnt_d   = 4'd0;
                cand_d  = StIdle;
            end else begin
                cnt_d  = cnt_inc;
                cand_d = cls;
            end
        end

        unique case (state_d)
            StClimb: komut_d = 3'b001;
            StHold:  komut_d = 3'b010;
            StDesc:  komut_d = 3'b100;
            default: komut_d = 3'b000;
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            s1_gnss_q <= '0;
            s1_alt_q  <= '0;
            s1_tgt_q  <= '0;
            s1_vld_q  <= 1'b0;
            err_q     <= '0;
            diff_q    <= '0;
            s2_vld_q  <= 1'b0;
            state_q   <= StIdle;
            cand_q    <= StIdle;
            cnt_q     <= 4'd0;
            fault_q   <= 1'b0;
            valid_q   <= 1'b0;
            komut_q   <= 3'b000;
        end else begin
            s1_gnss_q <= s1_gnss_d;
            s1_alt_q  <= s1_alt_d;
            s1_tgt_q  <= s1_tgt_d;
            s1_vld_q  <= s1_vld_d;
            err_q     <= err_d;
            diff_q    <= diff_d;
            s2_vld_q  <= s2_vld_d;
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            fault_q   <= fault_d;
            valid_q   <= valid_d;
            komut_q   <= komut_d;
        end
    end

    assign bus.komut_o        = komut_q;
    assign bus.komut_valid_o  = valid_q;
    assign bus.sensor_fault_o = fault_q;

endmodule

// File: tb/tb_oto_pilot_ctrl.sv
// Bench for oto_pilot_ctrl: directed samples push expected commands into a scoreboard queue,
// a monitor pops and compares three clocks after each issued sample.
module tb_oto_pilot_ctrl;

    localparam logic [2:0] KC = 3'b001;
    localparam logic [2:0] KH = 3'b010;
    localparam logic [2:0] KD = 3'b100;

    typedef struct {
        logic [2:0] k;
        logic       v;
        logic       f;
        int         id;
    } exp_t;

    logic clock = 1'b0;
    logic resetb = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   n_id = 0;
    bit   issue_now = 1'b0;
    bit [2:0] hist = 3'b000;
    exp_t sb[$];

    oto_pilot_ctrl_if #(.W(6)) bus ();

    oto_pilot_ctrl #(
        .W        (6),
        .HYST     (2),
        .CONFIRM  (3),
        .FAULT_TH (8)
    ) dut (
        .clock  (clock),
        .resetb (resetb),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    task automatic check_now(input string name, input logic [2:0] ek, input logic ev,
                             input logic ef);
        total++;
        if (bus.komut_o !== ek || bus.komut_valid_o !== ev || bus.sensor_fault_o !== ef) begin
            bad++;
            $display("FAIL %s: got komut=%b valid=%b fault=%b, want komut=%b valid=%b fault=%b",
                     name, bus.komut_o, bus.komut_valid_o, bus.sensor_fault_o, ek, ev, ef);
        end
    endtask

    task automatic drive(input int g, input int a, input int t, input logic v,
                         input logic [2:0] ek, input logic ef);
        exp_t e;
        @(negedge clock);
        bus.gnss_i              = 6'(g);
        bus.altimetre_i         = 6'(a);
        bus.hedef_yukseklik_i   = 6'(t);
        bus.yukseklik_bilgisi_i = v;
        e.k = ek;
        e.v = 1'b1;
        e.f = ef;
        e.id = n_id;
        n_id++;
        sb.push_back(e);
        issue_now = 1'b1;
    endtask

    // Monitor: the result of a sample issued before edge N is visible after edge N+2.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (!resetb) begin
                hist = 3'b000;
                issue_now = 1'b0;
            end else begin
                hist = {hist[1:0], issue_now};
                issue_now = 1'b0;
                if (hist[2]) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL scoreboard: got output with empty queue, want entry");
                    end else begin
                        e = sb.pop_front();
                        if (bus.komut_o !== e.k || bus.komut_valid_o !== e.v ||
                            bus.sensor_fault_o !== e.f) begin
                            bad++;
                            $display("FAIL sample%0d: got komut=%b valid=%b fault=%b, want %b %b %b",
                                     e.id, bus.komut_o, bus.komut_valid_o, bus.sensor_fault_o,
                                     e.k, e.v, e.f);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.gnss_i = '0;
        bus.altimetre_i = '0;
        bus.hedef_yukseklik_i = '0;
        bus.yukseklik_bilgisi_i = 1'b0;
        #3 resetb = 1'b0;
        #1 check_now("reset", 3'b000, 1'b0, 1'b0);
        @(negedge clock);
        @(negedge clock);
        resetb = 1'b1;
        @(posedge clock);
        #1 check_now("idle_after_reset", 3'b000, 1'b0, 1'b0);

        // First decision, then asynchronous reset mid-stream
        repeat (4) drive(13, 12, 47, 1'b1, KC, 1'b0);
        #2 resetb = 1'b0;
        sb.delete();
        #1 check_now("async_reset", 3'b000, 1'b0, 1'b0);
        bus.yukseklik_bilgisi_i = 1'b0;
        @(negedge clock);
        @(negedge clock);
        resetb = 1'b1;
        @(posedge clock);
        #1 check_now("idle_after_reset2", 3'b000, 1'b0, 1'b0);

        // Climb, then debounced switch to hold
        drive(13, 12, 47, 1'b1, KC, 1'b0);
        drive(13, 12, 12, 1'b1, KC, 1'b0);
        drive(13, 12, 12, 1'b1, KC, 1'b0);
        drive(13, 12, 12, 1'b1, KH, 1'b0);

        // Hysteresis edges around fused=20
        repeat (3) drive(20, 20, 22, 1'b1, KH, 1'b0);
        drive(20, 20, 23, 1'b1, KH, 1'b0);
        drive(20, 20, 23, 1'b1, KH, 1'b0);
        drive(20, 20, 23, 1'b1, KC, 1'b0);
        drive(20, 20, 17, 1'b1, KC, 1'b0);
        drive(20, 20, 17, 1'b1, KC, 1'b0);
        drive(20, 20, 17, 1'b1, KD, 1'b0);

        // Back to climb, then a sensor fault forces hold immediately
        drive(10, 10, 47, 1'b1, KD, 1'b0);
        drive(10, 10, 47, 1'b1, KD, 1'b0);
        drive(10, 10, 47, 1'b1, KC, 1'b0);
        drive(40, 10, 47, 1'b1, KH, 1'b1);
        drive(10, 10, 47, 1'b1, KH, 1'b0);
        drive(10, 10, 47, 1'b1, KH, 1'b0);
        drive(10, 10, 47, 1'b1, KC, 1'b0);

        // To hold, err=-2 stays hold, then interrupted descend run
        drive(20, 20, 20, 1'b1, KC, 1'b0);
        drive(20, 20, 20, 1'b1, KC, 1'b0);
        drive(20, 20, 20, 1'b1, KH, 1'b0);
        repeat (3) drive(20, 20, 18, 1'b1, KH, 1'b0);
        drive(20, 20, 17, 1'b1, KH, 1'b0);
        drive(20, 20, 17, 1'b1, KH, 1'b0);
        drive(20, 20, 20, 1'b1, KH, 1'b0);
        drive(20, 20, 17, 1'b1, KH, 1'b0);
        drive(20, 20, 17, 1'b1, KH, 1'b0);
        drive(20, 20, 17, 1'b1, KD, 1'b0);

        // Valid gap clears a pending descend run
        drive(20, 20, 20, 1'b1, KD, 1'b0);
        drive(20, 20, 20, 1'b1, KD, 1'b0);
        drive(20, 20, 20, 1'b1, KH, 1'b0);
        drive(20, 20, 17, 1'b1, KH, 1'b0);
        drive(20, 20, 17, 1'b1, KH, 1'b0);
        repeat (5) drive(20, 20, 17, 1'b0, KH, 1'b0);
        drive(20, 20, 17, 1'b1, KH, 1'b0);
        drive(20, 20, 17, 1'b1, KH, 1'b0);
        drive(20, 20, 17, 1'b1, KD, 1'b0);

        @(negedge clock);
        bus.yukseklik_bilgisi_i = 1'b0;
        repeat (5) @(negedge clock);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
